// File: rtl/wam_pkg.sv
// Shared types and constants for the whack-a-mole round sequencer.
package wam_pkg;

  localparam int unsigned WAM_NUM_MOLES = 9;
  localparam int unsigned TICK_W        = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_GAP,
    ST_PICK,
    ST_UP,
    ST_OVER
  } state_t;

  function automatic logic [TICK_W-1:0] gap_ticks(input logic [1:0] lvl);
    logic [TICK_W-1:0] t;
    case (lvl)
      2'd0:    t = 12'd2000;
      2'd1:    t = 12'd1000;
      2'd2:    t = 12'd1000;
      default: t = 12'd500;
    endcase
    return t;
  endfunction

  function automatic logic [TICK_W-1:0] up_ticks(input logic [1:0] lvl);
    logic [TICK_W-1:0] t;
    case (lvl)
      2'd0:    t = 12'd2000;
      2'd1:    t = 12'd1000;
      2'd2:    t = 12'd500;
      default: t = 12'd250;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// DIV-cycle prescaler feeding a tick counter; o_done flags the last cycle
// of an interval of i_target ticks measured from the most recent clear.
module tick_timer
  import wam_pkg::*;
#(
  parameter int unsigned DIV = 50000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic [TICK_W-1:0] i_target,
  output logic              o_done
);

  localparam int unsigned   PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0]     r_pre;
  logic [TICK_W-1:0] r_ticks;
  logic              w_wrap;

  assign w_wrap = (r_pre == PRE_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_pre   <= '0;
      r_ticks <= '0;
    end else if (w_wrap) begin
      r_pre   <= '0;
      r_ticks <= r_ticks + TICK_W'(1);
    end else begin
      r_pre   <= r_pre + PW'(1);
    end
  end

  // Done is asserted combinationally so the owner leaves on exactly the last cycle.
  assign o_done = w_wrap && (r_ticks == i_target - TICK_W'(1));

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole round sequencer: lights one mole, waits for hit or timeout,
// keeps score/misses. Optional macro WAM_WRONG_PENALTY_EN counts wrong whacks as misses.
module mole_scheduler
  import wam_pkg::*;
#(
  parameter int unsigned NUM_MOLES  = WAM_NUM_MOLES,
  parameter int unsigned DIV        = 50000,
  parameter int unsigned MAX_MISSES = 3,
  parameter int unsigned SCORE_W    = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           level,
  input  logic [3:0]           rand_idx,
  input  logic [NUM_MOLES-1:0] whack,
  output logic [NUM_MOLES-1:0] mole,
  output logic [SCORE_W-1:0]   score,
  output logic [1:0]           misses,
  output logic                 busy,
  output logic                 game_over
);

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_level;
  logic [3:0]           r_idx;
  logic [SCORE_W-1:0]   r_score;
  logic [1:0]           r_misses;
  logic [NUM_MOLES-1:0] w_lit;
  logic [3:0]           w_pick_idx;
  logic [1:0]           w_miss_next;
  logic [TICK_W-1:0]    w_target;
  logic                 w_hit;
  logic                 w_wrong;
  logic                 w_done;
  logic                 w_clear;
  logic                 w_score_inc;
  logic                 w_miss_inc;

  assign w_lit       = NUM_MOLES'(1) << r_idx;
  assign w_hit       = |(whack & w_lit);
  assign w_miss_next = r_misses + 2'd1;
  assign w_pick_idx  = ({1'b0, rand_idx} < 5'(NUM_MOLES)) ? rand_idx
                                                          : rand_idx - 4'(NUM_MOLES);
  assign w_target    = (r_state == ST_UP) ? up_ticks(r_level) : gap_ticks(r_level);

`ifdef WAM_WRONG_PENALTY_EN
  assign w_wrong = !w_hit && (|whack);
`else
  assign w_wrong = 1'b0;
`endif

  tick_timer #(
    .DIV (DIV)
  ) u_timer (
    .i_clk    (CLOCK_50),
    .i_rst    (reset),
    .i_clear  (w_clear),
    .i_target (w_target),
    .o_done   (w_done)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // One timer serves GAP and UP, so it is cleared on every entry to either.
  always_comb begin
    w_next      = r_state;
    w_clear     = 1'b0;
    w_score_inc = 1'b0;
    w_miss_inc  = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_ARM;
      ST_ARM: begin
        w_next  = ST_GAP;
        w_clear = 1'b1;
      end
      ST_GAP:  if (w_done) w_next = ST_PICK;
      ST_PICK: begin
        w_next  = ST_UP;
        w_clear = 1'b1;
      end
      ST_UP: begin
        if (w_hit) begin
          w_score_inc = 1'b1;
          w_clear     = 1'b1;
          w_next      = ST_GAP;
        end else if (w_done || w_wrong) begin
          w_miss_inc = 1'b1;
          w_clear    = 1'b1;
          w_next     = (w_miss_next == 2'(MAX_MISSES)) ? ST_OVER : ST_GAP;
        end
      end
      ST_OVER: if (start) w_next = ST_ARM;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_level  <= '0;
      r_idx    <= '0;
      r_score  <= '0;
      r_misses <= '0;
    end else begin
      if (r_state == ST_ARM) begin
        r_level  <= level;
        r_score  <= '0;
        r_misses <= '0;
      end
      if (r_state == ST_PICK) r_idx <= w_pick_idx;
      if (w_score_inc && (r_score != '1)) r_score <= r_score + SCORE_W'(1);
      if (w_miss_inc) r_misses <= w_miss_next;
    end
  end

  assign mole      = (r_state == ST_UP) ? w_lit : '0;
  assign score     = r_score;
  assign misses    = r_misses;
  assign busy      = (r_state == ST_ARM) || (r_state == ST_GAP) ||
                     (r_state == ST_PICK) || (r_state == ST_UP);
  assign game_over = (r_state == ST_OVER);

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler at DIV=1, level 3 (gap 500 / up 250), SCORE_W=2.
module tb_mole_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] level;
  logic [3:0] rand_idx;
  logic [8:0] whack;
  logic [8:0] mole;
  logic [1:0] score;
  logic [1:0] misses;
  logic       busy;
  logic       game_over;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mole_scheduler #(
    .NUM_MOLES  (9),
    .DIV        (1),
    .MAX_MISSES (3),
    .SCORE_W    (2)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .start     (start),
    .level     (level),
    .rand_idx  (rand_idx),
    .whack     (whack),
    .mole      (mole),
    .score     (score),
    .misses    (misses),
    .busy      (busy),
    .game_over (game_over)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; level = 2'd0; rand_idx = 4'd0; whack = '0;
    step(2);
    reset = 1'b0;
    step(1);
    chk("rst_mole", 32'(mole), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_misses", 32'(misses), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_over", 32'(game_over), 0);

    // start latency at level 3: ARM, 500 GAP cycles, PICK, then UP
    level = 2'd3; rand_idx = 4'd4; start = 1'b1;
    step(1);
    start = 1'b0;
    chk("arm_busy", 32'(busy), 1);
    step(501);
    chk("pick_mole_off", 32'(mole), 0);
    step(1);
    chk("first_light", 32'(mole), 32'h010);

    step(2);
    whack = 9'h010;
    step(1);
    whack = '0;
    chk("hit_mole", 32'(mole), 0);
    chk("hit_score", 32'(score), 1);
    chk("hit_busy", 32'(busy), 1);

    rand_idx = 4'd13;
    step(500);
    chk("gap_len_mole_off", 32'(mole), 0);
    step(1);
    chk("wrap_light", 32'(mole), 32'h010);

    step(249);
    chk("last_up_lit", 32'(mole), 32'h010);
    whack = 9'h010;
    step(1);
    whack = '0;
    chk("tie_score", 32'(score), 2);
    chk("tie_misses", 32'(misses), 0);
    chk("tie_mole", 32'(mole), 0);

    rand_idx = 4'd4;
    step(501);
    chk("wrong_pre_light", 32'(mole), 32'h010);
    whack = 9'h001;
    step(1);
    whack = '0;
`ifdef WAM_WRONG_PENALTY_EN
    chk("wrong_misses", 32'(misses), 1);
    chk("wrong_mole", 32'(mole), 0);
`else
    chk("wrong_ignored_misses", 32'(misses), 0);
    chk("wrong_ignored_mole", 32'(mole), 32'h010);
    step(248);
    chk("to1_last_lit", 32'(mole), 32'h010);
    step(1);
    chk("to1_misses", 32'(misses), 1);
    chk("to1_mole", 32'(mole), 0);
`endif

    step(501);
    chk("to2_light", 32'(mole), 32'h010);
    step(249);
    chk("to2_last_lit", 32'(mole), 32'h010);
    step(1);
    chk("to2_misses", 32'(misses), 2);
    chk("to2_mole", 32'(mole), 0);
    chk("to2_busy", 32'(busy), 1);
    chk("to2_over", 32'(game_over), 0);

    step(501);
    step(250);
    chk("to3_misses", 32'(misses), 3);
    chk("to3_over", 32'(game_over), 1);
    chk("to3_busy", 32'(busy), 0);
    chk("to3_mole", 32'(mole), 0);
    chk("to3_score", 32'(score), 2);

    whack = 9'h010;
    step(5);
    whack = '0;
    chk("over_score_hold", 32'(score), 2);
    chk("over_misses_hold", 32'(misses), 3);
    chk("over_stays", 32'(game_over), 1);

    // restart; level change and start pulse mid-GAP must not disturb timing
    level = 2'd3; rand_idx = 4'd15; start = 1'b1;
    step(1);
    start = 1'b0;
    chk("restart_busy", 32'(busy), 1);
    step(1);
    chk("restart_score", 32'(score), 0);
    chk("restart_misses", 32'(misses), 0);
    level = 2'd0; start = 1'b1;
    step(1);
    start = 1'b0;
    step(498);
    chk("busy_start_mole_off", 32'(mole), 0);
    step(1);
    chk("pick2_mole_off", 32'(mole), 0);
    step(1);
    chk("idx15_light", 32'(mole), 32'h040);

    for (int i = 1; i <= 4; i++) begin
      whack = 9'h040;
      step(1);
      whack = '0;
      chk($sformatf("sat_score%0d", i), 32'(score), (i > 3) ? 32'd3 : 32'(i));
      step(501);
      chk($sformatf("sat_light%0d", i), 32'(mole), 32'h040);
    end

    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("midrst_mole", 32'(mole), 0);
    chk("midrst_score", 32'(score), 0);
    chk("midrst_misses", 32'(misses), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_over", 32'(game_over), 0);
    step(3);
    chk("idle_holds", 32'(busy), 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("idle_start", 32'(busy), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
